// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register-address width, hazard FSM states
// and the source-operand match helper used by the stall/flush controller.
package pipeline_pkg;

    localparam int unsigned REG_W     = 5;
    localparam int unsigned DEF_CNT_W = 16;

    typedef logic [REG_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } hazard_state_t;

    // True when a producer register feeds a source of the ID instruction; $zero never does.
    function automatic logic regMatch(
        input reg_addr_t r,
        input reg_addr_t rs,
        input reg_addr_t rt,
        input logic      usesRt
    );
        return (r != REG_ZERO) && ((r == rs) || (usesRt && (r == rt)));
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard-controller bundle: pipeline status in, stall/flush controls and statistics out.
interface hazard_unit_if
    import pipeline_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
);

    reg_addr_t        ifid_rs;
    reg_addr_t        ifid_rt;
    logic             ifid_uses_rt;
    logic             id_branch;
    logic             id_branch_taken;
    logic             id_jump;
    logic             idex_mem_read;
    logic             idex_reg_write;
    reg_addr_t        idex_rd;
    logic             exmem_mem_read;
    reg_addr_t        exmem_rd;
    logic             dmem_req;
    logic             dmem_ready;

    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pipe_hold;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_timeout;

    modport master (
        output ifid_rs, ifid_rt, ifid_uses_rt, id_branch, id_branch_taken, id_jump,
               idex_mem_read, idex_reg_write, idex_rd, exmem_mem_read, exmem_rd,
               dmem_req, dmem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold,
               stall_cnt, flush_cnt, mem_timeout
    );

    modport slave (
        input  ifid_rs, ifid_rt, ifid_uses_rt, id_branch, id_branch_taken, id_jump,
               idex_mem_read, idex_reg_write, idex_rd, exmem_mem_read, exmem_rd,
               dmem_req, dmem_ready,
        output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold,
               stall_cnt, flush_cnt, mem_timeout
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline: Mealy control outputs,
// saturating stall/flush statistics and a memory-wait watchdog.
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned TIMEOUT = 64
) (
    input logic         clk,
    input logic         rst_n,
    hazard_unit_if.slave hz
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    logic loadUse;
    logic brHaz;
    logic memWait;
    logic stallCycle;

    hazard_state_t    state;
    logic [CNT_W-1:0] waitCtr;
    logic             memTimeout;

    always_comb begin
        loadUse = hz.idex_mem_read
                  && regMatch(hz.idex_rd, hz.ifid_rs, hz.ifid_rt, hz.ifid_uses_rt);
        brHaz   = hz.id_branch
                  && ((hz.idex_reg_write
                       && regMatch(hz.idex_rd, hz.ifid_rs, hz.ifid_rt, hz.ifid_uses_rt))
                      || (hz.exmem_mem_read
                       && regMatch(hz.exmem_rd, hz.ifid_rs, hz.ifid_rt, hz.ifid_uses_rt)));
        memWait = hz.dmem_req && !hz.dmem_ready;
    end

    // A frozen or stalled ID must not flush: redirect only when the branch/jump leaves ID.
    always_comb begin
        hz.pc_write    = 1'b1;
        hz.ifid_write  = 1'b1;
        hz.ifid_flush  = 1'b0;
        hz.idex_bubble = 1'b0;
        hz.pipe_hold   = 1'b0;
        if (memWait) begin
            hz.pipe_hold  = 1'b1;
            hz.pc_write   = 1'b0;
            hz.ifid_write = 1'b0;
        end else if (loadUse || brHaz) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_bubble = 1'b1;
        end else if ((hz.id_branch && hz.id_branch_taken) || hz.id_jump) begin
            hz.ifid_flush = 1'b1;
        end
    end

    assign stallCycle = memWait || loadUse || brHaz;

    // Watchdog: waitCtr counts consecutive wait cycles; reaching TIMEOUT latches ERR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            waitCtr    <= '0;
            memTimeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (memWait) begin
                        state   <= WAIT;
                        waitCtr <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (!memWait) begin
                        state <= RUN;
                    end else if (waitCtr == WAIT_LAST) begin
                        state      <= ERR;
                        memTimeout <= 1'b1;
                    end else begin
                        waitCtr <= waitCtr + 1'b1;
                    end
                end
                ERR: begin
                    memTimeout <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign hz.mem_timeout = memTimeout;

    sat_counter #(
        .W (CNT_W)
    ) stallCounter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stallCycle),
        .count (hz.stall_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) flushCounter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hz.ifid_flush),
        .count (hz.flush_cnt)
    );

endmodule
